// File: rtl/vip_pkg.sv
// rtl/vip_pkg.sv - shared FSM states and matrix alignment latency for the vip window pipeline
package vip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2
  } vip_state_e;

  // Sync delay of the 3x3 matrix generator; window flags must land on the same cycle.
  localparam int VIP_MATRIX_LAT = 2;

endpackage

// File: rtl/vip_edge_detect.sv
// rtl/vip_edge_detect.sv - rise/fall pulses of a strobe against its registered previous value
module vip_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/vip_matrix_window_ctrl.sv
// rtl/vip_matrix_window_ctrl.sv - frame/line sequencer qualifying 3x3 windows alongside the matrix generator
module vip_matrix_window_ctrl
  import vip_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             win_valid,
  output logic             win_border,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
  output logic             line_err,
  output logic             frame_err
);

  localparam int CMP_W = ((COL_W > ROW_W) ? COL_W : ROW_W) + 1;
  localparam logic [CMP_W-1:0] WIDTH_C   = CMP_W'(IMG_WIDTH);
  localparam logic [CMP_W-1:0] HEIGHT_C  = CMP_W'(IMG_HEIGHT);
  localparam logic [CMP_W-1:0] WIDTH_M1  = CMP_W'(IMG_WIDTH - 1);
  localparam logic [CMP_W-1:0] HEIGHT_M1 = CMP_W'(IMG_HEIGHT - 1);
  localparam logic [CMP_W-1:0] TWO       = CMP_W'(2);
  localparam logic [COL_W-1:0] COL_MAX   = '1;
  localparam logic [ROW_W-1:0] ROW_MAX   = '1;

  vip_state_e state, state_nxt;
  logic frame_clr;
  logic vs_rise, vs_fall, hs_fall, unused_hs_rise;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [CMP_W-1:0] col_ext, row_ext;
  logic pix_acc, line_end, done_evt, win_ok, border_ok;
  logic s1_valid, s1_border;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic [VIP_MATRIX_LAT-1:0] done_pipe;

  // vsync history resets high so a frame already in progress at reset release is not picked up.
  vip_edge_detect #(.RST_VAL(1'b1)) u_vsync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (per_frame_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vip_edge_detect #(.RST_VAL(1'b0)) u_href_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (per_frame_href),
    .rise (unused_hs_rise),
    .fall (hs_fall)
  );

  assign col_ext   = CMP_W'(col_cnt);
  assign row_ext   = CMP_W'(row_cnt);
  assign pix_acc   = (state == ACTIVE) && per_frame_href && per_frame_clken;
  assign line_end  = (state == ACTIVE) && hs_fall;
  assign done_evt  = line_end && (row_ext == HEIGHT_M1);
  assign win_ok    = (row_ext >= TWO) && (col_ext >= TWO) && (row_ext < HEIGHT_C) && (col_ext < WIDTH_C);
  // Centre at (r-1, c-1) touches the image edge when c-1 is 1 or W-2, likewise for rows.
  assign border_ok = (col_ext == TWO) || (col_ext == WIDTH_M1) || (row_ext == TWO) || (row_ext == HEIGHT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_clr = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nxt = ACTIVE;
          frame_clr = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise || vs_fall) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (per_frame_vsync) begin
          state_nxt = ACTIVE;
          frame_clr = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      line_err <= 1'b0;
    end else if (frame_clr) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      line_err <= 1'b0;
    end else if (line_end) begin
      col_cnt <= '0;
      if (row_cnt != ROW_MAX) begin
        row_cnt <= row_cnt + 1'b1;
      end
      if (col_ext != WIDTH_C) begin
        line_err <= 1'b1;
      end
    end else if (pix_acc && (col_cnt != COL_MAX)) begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // A clear from CHECK wins over the row check made in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (frame_clr) begin
      frame_err <= 1'b0;
    end else if ((state == CHECK) && (row_ext != HEIGHT_C)) begin
      frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_border  <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      win_valid  <= 1'b0;
      win_border <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      done_pipe  <= '0;
    end else begin
      s1_valid <= pix_acc && win_ok;
      if (pix_acc && win_ok) begin
        s1_border <= border_ok;
        s1_col    <= col_cnt - 1'b1;
        s1_row    <= row_cnt - 1'b1;
      end
      win_valid <= s1_valid;
      if (s1_valid) begin
        win_border <= s1_border;
        win_col    <= s1_col;
        win_row    <= s1_row;
      end
      done_pipe <= {done_pipe[VIP_MATRIX_LAT-2:0], done_evt};
    end
  end

  assign frame_done = done_pipe[VIP_MATRIX_LAT-1];

endmodule

// File: tb/tb_vip_matrix_window_ctrl.sv
// tb/tb_vip_matrix_window_ctrl.sv - randomized scoreboard bench for vip_matrix_window_ctrl
module tb_vip_matrix_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 4;
  localparam int RW = 3;
  localparam int W2 = 40;
  localparam int H2 = 30;
  localparam int CW2 = 6;
  localparam int RW2 = 5;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic        border;
    logic [31:0] at;
  } win_t;

  logic clk;
  logic rst_n, vsync, href, clken;
  logic win_valid, win_border, frame_done, line_err, frame_err;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic b_win_valid, b_win_border, b_frame_done, b_line_err, b_frame_err;
  logic [CW2-1:0] b_win_col;
  logic [RW2-1:0] b_win_row;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int b_cnt = 0;
  int b_done = 0;
  int b_max_col = 0;
  int b_max_row = 0;
  win_t obs_q[$];
  win_t exp_q[$];
  int lens[64];
  int exp_done, exp_lerr, exp_ferr;

  vip_matrix_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .win_valid(win_valid), .win_border(win_border), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err)
  );

  vip_matrix_window_ctrl #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2), .COL_W(CW2), .ROW_W(RW2)) dut_big (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .win_valid(b_win_valid), .win_border(b_win_border), .win_col(b_win_col), .win_row(b_win_row),
    .frame_done(b_frame_done), .line_err(b_line_err), .frame_err(b_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid) obs_q.push_back('{16'(win_col), 16'(win_row), win_border, 32'(cyc)});
    if (frame_done) done_cnt <= done_cnt + 1;
    if (b_frame_done) b_done <= b_done + 1;
    if (b_win_valid) begin
      b_cnt <= b_cnt + 1;
      if (int'(b_win_col) > b_max_col) b_max_col <= int'(b_win_col);
      if (int'(b_win_row) > b_max_row) b_max_row <= int'(b_win_row);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame of nlines lines (lengths from lens[]) and builds the expected window list.
  task automatic drive_frame(input int nlines, input int mode);
    int c, k;
    exp_q.delete();
    exp_lerr = 0;
    exp_ferr = (nlines != H) ? 1 : 0;
    exp_done = (nlines >= H) ? 1 : 0;
    step(); vsync = 1'b1;
    repeat (2) step();
    for (int r = 0; r < nlines; r++) begin
      c = 0;
      k = 0;
      if (lens[r] != W) exp_lerr = 1;
      while (c < lens[r]) begin
        step();
        href = 1'b1;
        case (mode)
          0: clken = 1'b1;
          1: clken = (k % 2 == 0);
          default: clken = ($urandom_range(0, 99) < 60);
        endcase
        k++;
        if (clken) begin
          if (r >= 2 && c >= 2 && r < H && c < W)
            exp_q.push_back('{16'(c - 1), 16'(r - 1),
                              (c - 1 == 1) || (c - 1 == W - 2) || (r - 1 == 1) || (r - 1 == H - 2),
                              32'(cyc + 2)});
          c++;
        end
      end
      step(); href = 1'b0; clken = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
    step(); vsync = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({win_valid, win_border, win_col, win_row, frame_done, line_err, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b want=0", {win_valid, win_border, win_col, win_row, frame_done, line_err, frame_err});
    end
    checks++;
    if ({b_win_valid, b_win_col, b_win_row, b_frame_done, b_line_err, b_frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_state_big got=%b want=0", {b_win_valid, b_win_col, b_win_row, b_frame_done, b_line_err, b_frame_err});
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_full_size();
    int c0, d0;
    for (int i = 0; i < H2; i++) lens[i] = W2;
    c0 = b_cnt;
    d0 = b_done;
    drive_frame(H2, 0);
    checks++;
    if (b_cnt - c0 != (W2 - 2) * (H2 - 2)) begin
      failures++; $display("FAIL full_count got=%0d want=%0d", b_cnt - c0, (W2 - 2) * (H2 - 2));
    end
    checks++;
    if (b_max_col != W2 - 2 || b_max_row != H2 - 2) begin
      failures++; $display("FAIL full_max got=%0d/%0d want=%0d/%0d", b_max_col, b_max_row, W2 - 2, H2 - 2);
    end
    checks++;
    if (b_done - d0 != 1 || b_line_err !== 1'b0 || b_frame_err !== 1'b0) begin
      failures++; $display("FAIL full_status got done=%0d le=%b fe=%b want done=1 le=0 fe=0", b_done - d0, b_line_err, b_frame_err);
    end
  endtask

  task automatic test_clean_frame();
    int o0, d0;
    win_t g;
    for (int i = 0; i < H; i++) lens[i] = W;
    o0 = obs_q.size();
    d0 = done_cnt;
    drive_frame(H, 0);
    checks++;
    if (obs_q.size() - o0 != 12) begin
      failures++; $display("FAIL clean_count got=%0d want=12", obs_q.size() - o0);
    end
    g = (obs_q.size() > o0) ? obs_q[o0] : '0;
    checks++;
    if (g.col !== 16'd1 || g.row !== 16'd1 || g.border !== 1'b1) begin
      failures++; $display("FAIL clean_first got col=%0d row=%0d b=%b want col=1 row=1 b=1", g.col, g.row, g.border);
    end
    foreach (exp_q[i]) begin
      g = (o0 + i < obs_q.size()) ? obs_q[o0 + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL clean_win[%0d] got=%h want=%h", i, g, exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || line_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL clean_status got done=%0d le=%b fe=%b want done=1 le=0 fe=0", done_cnt - d0, line_err, frame_err);
    end
  endtask

  task automatic test_half_duty();
    int o0;
    win_t g;
    for (int i = 0; i < H; i++) lens[i] = W;
    o0 = obs_q.size();
    drive_frame(H, 1);
    checks++;
    if (obs_q.size() - o0 != 12) begin
      failures++; $display("FAIL half_count got=%0d want=12", obs_q.size() - o0);
    end
    foreach (exp_q[i]) begin
      g = (o0 + i < obs_q.size()) ? obs_q[o0 + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL half_win[%0d] got=%h want=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_short_line();
    for (int i = 0; i < H; i++) lens[i] = W;
    lens[1] = W - 1;
    drive_frame(H, 0);
    checks++;
    if (line_err !== 1'b1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL short_line_sticky got le=%b fe=%b want le=1 fe=0", line_err, frame_err);
    end
    lens[1] = W;
    drive_frame(H, 0);
    checks++;
    if (line_err !== 1'b0) begin
      failures++; $display("FAIL short_line_clear got=%b want=0", line_err);
    end
  endtask

  task automatic test_vsync_drop();
    int d0;
    for (int i = 0; i < H; i++) lens[i] = W;
    d0 = done_cnt;
    drive_frame(H - 1, 0);
    checks++;
    if (frame_err !== 1'b1 || done_cnt - d0 != 0) begin
      failures++; $display("FAIL drop_err got fe=%b done=%0d want fe=1 done=0", frame_err, done_cnt - d0);
    end
    drive_frame(H, 0);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL drop_clear got=%b want=0", frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int o0, d0;
    win_t g;
    step(); vsync = 1'b1;
    repeat (2) step();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 2) ? 5 : W); c++) begin
        step(); href = 1'b1; clken = 1'b1;
      end
      if (r < 2) begin
        step(); href = 1'b0; clken = 1'b0;
        step();
      end
    end
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({win_valid, win_border, win_col, win_row, frame_done, line_err, frame_err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b want=0", {win_valid, win_border, win_col, win_row, frame_done, line_err, frame_err});
    end
    href = 1'b0; clken = 1'b0; vsync = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    for (int i = 0; i < H; i++) lens[i] = W;
    o0 = obs_q.size();
    d0 = done_cnt;
    drive_frame(H, 0);
    checks++;
    if (obs_q.size() - o0 != 12 || done_cnt - d0 != 1 || line_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_frame got cnt=%0d done=%0d le=%b fe=%b want cnt=12 done=1 le=0 fe=0",
               obs_q.size() - o0, done_cnt - d0, line_err, frame_err);
    end
    foreach (exp_q[i]) begin
      g = (o0 + i < obs_q.size()) ? obs_q[o0 + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL midreset_win[%0d] got=%h want=%h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int o0, d0, nl;
    win_t g;
    for (int f = 0; f < 4; f++) begin
      nl = $urandom_range(H - 1, H + 1);
      for (int i = 0; i < nl; i++) lens[i] = $urandom_range(W - 1, W + 1);
      o0 = obs_q.size();
      d0 = done_cnt;
      drive_frame(nl, 2);
      checks++;
      if (obs_q.size() - o0 != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d want=%0d", f, obs_q.size() - o0, exp_q.size());
      end
      foreach (exp_q[i]) begin
        g = (o0 + i < obs_q.size()) ? obs_q[o0 + i] : '0;
        checks++;
        if (g !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_win[%0d] got=%h want=%h", f, i, g, exp_q[i]);
        end
      end
      checks++;
      if (done_cnt - d0 != exp_done || line_err !== 1'(exp_lerr) || frame_err !== 1'(exp_ferr)) begin
        failures++;
        $display("FAIL rand%0d_status got done=%0d le=%b fe=%b want done=%0d le=%0d fe=%0d",
                 f, done_cnt - d0, line_err, frame_err, exp_done, exp_lerr, exp_ferr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    clken = 1'b0;
    test_reset();
    test_full_size();
    test_clean_frame();
    test_half_duty();
    test_short_line();
    test_vsync_drop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
